pixel_stream_tx: RTL and testbench
==================================

# pixel_stream_tx

Transmit side of the filter pixel interface: buffers pixels from an upstream ready/valid source and drives the `data` / `data_valid_in` stream that the 3x3 line-buffer filter consumes. Each row is emitted as exactly LINE_W contiguous valid cycles, followed by HBLANK idle cycles, so the filter controller sees clean row boundaries. After ROWS rows it inserts VBLANK idle cycles, ending the frame. Sits between the CCD capture/DMA path and `two_d_filter`.

## Interface
- DATA_W, 10, pixel width; must match the filter data width.
- LINE_W, 640, pixels per row; 2..1024 (filter RAM address is 10 bits).
- ROWS, 480, rows per frame; at least 1.
- HBLANK, 16, idle cycles after each row except the last; at least 1.
- VBLANK, 64, idle cycles after the last row; at least 1.
- FIFO_DEPTH, 8, input buffer entries; a power of two, at least 2.
- clk  in  1  clock.
- aclr  in  1  asynchronous active-low reset.
- in_data  in  DATA_W  upstream pixel.
- in_valid  in  1  upstream pixel present.
- in_ready  out  1  equals !fifo_full (combinational).
- start  in  1  level; sampled in IDLE to begin a frame.
- data  out  DATA_W  pixel to the filter; registered.
- data_valid  out  1  drives filter `data_valid_in`; registered.
- row_end  out  1  high with the last pixel of each row.
- frame_end  out  1  high with the last pixel of the last row.
- busy  out  1  high in every state except IDLE.
- underrun  out  1  sticky flag; set on a pop from an empty FIFO.
- clear_underrun  in  1  synchronous clear of underrun.

## Operation
- Reset values:
  - data=0, data_valid=0, row_end=0, frame_end=0, busy=0, underrun=0.
  - FIFO empty, so in_ready=1.
  - State IDLE; column counter and row counter both 0.
- FIFO push: on in_valid && in_ready.
- FSM states: IDLE, PRIME, ACTIVE, HBLANK, VBLANK.
  - IDLE: if start=1, go to PRIME and clear the row counter.
  - PRIME: wait while the FIFO count is below min(FIFO_DEPTH, LINE_W). When the count is reached, go to ACTIVE and clear the column counter.
  - ACTIVE: every cycle emits one pixel and increments the column counter.
    - If the FIFO is non-empty, pop and emit the popped pixel.
    - If the FIFO is empty, emit 0 with data_valid still 1, and set underrun. There is no bypass: a push and a pop in the same cycle on an empty FIFO is an underrun.
    - At column LINE_W-1: if this is the last row, go to VBLANK; otherwise go to HBLANK.
  - HBLANK: count HBLANK cycles, increment the row counter, then go to PRIME.
  - VBLANK: count VBLANK cycles, then go to IDLE. If start is still high, IDLE immediately re-enters PRIME on the next edge (back-to-back frames).
- Outside ACTIVE, data_valid=0 and data holds 0.
- start is ignored outside IDLE. Pushes continue in every state, so the next row prefetches during HBLANK/VBLANK.
- underrun: set has priority over clear_underrun in the same cycle. It clears only via clear_underrun or reset.
- aclr mid-frame: all outputs go to their reset values immediately and the FIFO is flushed. A new frame requires start.

## Timing
- start sampled at edge t with the FIFO already primed: PRIME at t+1, first data_valid=1 visible after edge t+2.
- data_valid is high for exactly LINE_W consecutive cycles per row. No gaps are allowed inside a row; an underrun pads with 0 rather than stalling.
- Gap between rows is at least HBLANK+1 cycles of data_valid=0 (HBLANK plus at least one PRIME cycle).
- row_end and frame_end are single-cycle pulses, coincident with their data_valid pixel.
- in_ready responds to the full state of the same cycle. A pop does not free a slot for a push until the next cycle.

## Configuration
- PIX_TX_TESTPAT_EN defined:
  - Adds input `testpat` (1 bit, sampled with start in IDLE and held for the whole frame).
  - When testpat=1, ACTIVE emits (row+col) truncated to DATA_W. The FIFO is not popped, PRIME does not wait, and underrun never sets.
- PIX_TX_TESTPAT_EN undefined: the port and its logic are absent.

## Structure
- Shared package `pix_stream_pkg`:
  - State enum.
  - Constants DATA_W=10 and MAX_LINE_W=1024.
  - Counter width function clog2.
- One sub-module `pix_sync_fifo`:
  - Ports: push/pop, data in/out, count, full, empty.
  - Asynchronous active-low clear.
- FSM, counters and output registers live in `pixel_stream_tx`.

## Test plan
Unless noted: LINE_W=4, ROWS=2, HBLANK=2, VBLANK=3, FIFO_DEPTH=4.
- Reset, then push 8 pixels 1..8 and pulse start → data_valid windows carry 1,2,3,4 and then 5,6,7,8. row_end is high on 4 and on 8; frame_end only on 8; at least 3 idle cycles between the rows; busy falls after VBLANK.
- Hold in_valid=0 after pushing 4 pixels, then start → row 0 is 1..4; row 1 stays in PRIME with data_valid=0 until 4 more pixels arrive; underrun stays 0.
- Push 4, start, then stall the source during row 1 after supplying only 2 pixels (LINE_W=4, FIFO_DEPTH=2, so PRIME releases with 2 buffered) → row 1 emits 5,6,0,0 with data_valid continuous and underrun=1; clear_underrun returns it to 0.
- Fill the FIFO while in IDLE → in_ready=0 with count=4; the pixel offered while in_ready=0 is not accepted and is not lost upstream.
- Assert aclr on the second pixel of row 1 → data_valid=0 and busy=0 immediately, in_ready=1; a subsequent start with 8 fresh pixels produces a correct frame.
- With PIX_TX_TESTPAT_EN defined, testpat=1 and start, no pushes → rows emit 0,1,2,3 and 1,2,3,4; underrun stays 0.

Source files
------------

// File: rtl/pix_stream_pkg.sv
// pix_stream_pkg: state encoding, shared constants and counter width helper for the pixel stream transmitter.
package pix_stream_pkg;
    localparam int DATA_W     = 10;
    localparam int MAX_LINE_W = 1024;
    typedef enum logic [2:0] {S_IDLE, S_PRIME, S_ACTIVE, S_HBLANK, S_VBLANK} state_t;
    function automatic int clog2(input int v);
        int r;
        r = 1;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/pix_sync_fifo.sv
// pix_sync_fifo: single-clock pixel buffer; the caller gates push on !full_o and pop on !empty_o.
module pix_sync_fifo
    import pix_stream_pkg::*;
#(
    parameter int W     = DATA_W,
    parameter int DEPTH = 8,
    localparam int AW   = clog2(DEPTH)
)(
    input  logic          clk,
    input  logic          aclr,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  din_i,
    output logic [W-1:0]  dout_o,
    output logic [AW:0]   count_o,
    output logic          full_o,
    output logic          empty_o
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    always_ff @(posedge clk) if (push_i) mem_q[wr_q] <= din_i;
    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_q + AW'(push_i);
            rd_q  <= rd_q + AW'(pop_i);
            cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
        end
    end
    assign dout_o  = mem_q[rd_q];
    assign count_o = cnt_q;
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
endmodule

// File: rtl/pixel_stream_tx.sv
// pixel_stream_tx: buffers upstream pixels and emits fixed-length rows with H/V blanking to the 3x3 filter.
// Optional test-pattern generator enabled by defining PIX_TX_TESTPAT_EN.
module pixel_stream_tx
    import pix_stream_pkg::*;
#(
    parameter int DATA_W     = pix_stream_pkg::DATA_W,
    parameter int LINE_W     = 640,
    parameter int ROWS       = 480,
    parameter int HBLANK     = 16,
    parameter int VBLANK     = 64,
    parameter int FIFO_DEPTH = 8
)(
    input  logic              clk,
    input  logic              aclr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              start,
`ifdef PIX_TX_TESTPAT_EN
    input  logic              testpat,
`endif
    output logic [DATA_W-1:0] data,
    output logic              data_valid,
    output logic              row_end,
    output logic              frame_end,
    output logic              busy,
    output logic              underrun,
    input  logic              clear_underrun
);
    localparam int CW = clog2(MAX_LINE_W);
    localparam int RW = clog2(ROWS);
    localparam int BW = clog2(HBLANK > VBLANK ? HBLANK : VBLANK);
    localparam int AW = clog2(FIFO_DEPTH);
    localparam logic [AW:0] PRIME_N = (AW+1)'(FIFO_DEPTH < LINE_W ? FIFO_DEPTH : LINE_W);
    state_t            state_q;
    logic [CW-1:0]     col_q;
    logic [RW-1:0]     row_q;
    logic [BW-1:0]     blk_q;
    logic [DATA_W-1:0] data_q, fifo_dout, pix_d;
    logic              valid_q, row_end_q, frame_end_q, underrun_q;
    logic              full, empty, push, pop, active, last_col, last_row, tp;
    logic [AW:0]       count;
`ifdef PIX_TX_TESTPAT_EN
    logic tp_q;
    always_ff @(posedge clk or negedge aclr)
        if (!aclr) tp_q <= 1'b0;
        else if (state_q == S_IDLE && start) tp_q <= testpat;
    assign tp = tp_q;
`else
    assign tp = 1'b0;
`endif
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign active   = state_q == S_ACTIVE;
    assign pop      = active && !tp && !empty;
    assign last_col = col_q == CW'(LINE_W - 1);
    assign last_row = row_q == RW'(ROWS - 1);
    // No bypass: an empty FIFO pads with zero even if a push lands this cycle.
    assign pix_d    = tp ? DATA_W'(32'(row_q) + 32'(col_q)) : (empty ? '0 : fifo_dout);
    pix_sync_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .aclr(aclr), .push_i(push), .pop_i(pop), .din_i(in_data),
        .dout_o(fifo_dout), .count_o(count), .full_o(full), .empty_o(empty)
    );
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            blk_q       <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            row_end_q   <= 1'b0;
            frame_end_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            data_q      <= active ? pix_d : '0;
            valid_q     <= active;
            row_end_q   <= active && last_col;
            frame_end_q <= active && last_col && last_row;
            underrun_q  <= (active && !tp && empty) ? 1'b1 : (clear_underrun ? 1'b0 : underrun_q);
            case (state_q)
                S_IDLE: if (start) begin
                    state_q <= S_PRIME;
                    row_q   <= '0;
                end
                S_PRIME: if (tp || count >= PRIME_N) begin
                    state_q <= S_ACTIVE;
                    col_q   <= '0;
                end
                S_ACTIVE: begin
                    col_q <= col_q + 1'b1;
                    if (last_col) begin
                        state_q <= last_row ? S_VBLANK : S_HBLANK;
                        blk_q   <= '0;
                    end
                end
                S_HBLANK: begin
                    blk_q <= blk_q + 1'b1;
                    if (blk_q == BW'(HBLANK - 1)) begin
                        state_q <= S_PRIME;
                        row_q   <= row_q + 1'b1;
                    end
                end
                S_VBLANK: begin
                    blk_q <= blk_q + 1'b1;
                    if (blk_q == BW'(VBLANK - 1)) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
    assign data       = data_q;
    assign data_valid = valid_q;
    assign row_end    = row_end_q;
    assign frame_end  = frame_end_q;
    assign busy       = state_q != S_IDLE;
    assign underrun   = underrun_q;
endmodule

// File: tb/tb_pixel_stream_tx.sv
// tb_pixel_stream_tx: table-driven frame checks on a depth-4 instance (u_a) and a depth-2 instance (u_b).
module tb_pixel_stream_tx;
    typedef struct packed {logic [9:0] d; logic re; logic fe;} rec_t;
    logic       clk = 1'b0, aclr = 1'b0;
    logic [9:0] din [2];
    logic [9:0] dat [2];
    logic [1:0] vld, rdy, go_s, clr, dv, re, fe, busy, und;
`ifdef PIX_TX_TESTPAT_EN
    logic [1:0] tp;
`endif
    int   tests = 0, fails = 0;
    int   nxt [2], lim [2], run [2], gap [2], mingap [2], badrun [2], stray [2];
    bit   ended [2];
    rec_t cap0 [$], cap1 [$];
    rec_t tbl [24];
    always #5 clk = ~clk;
    pixel_stream_tx #(.DATA_W(10), .LINE_W(4), .ROWS(2), .HBLANK(2), .VBLANK(3), .FIFO_DEPTH(4)) u_a (
        .clk(clk), .aclr(aclr), .in_data(din[0]), .in_valid(vld[0]), .in_ready(rdy[0]), .start(go_s[0]),
`ifdef PIX_TX_TESTPAT_EN
        .testpat(tp[0]),
`endif
        .data(dat[0]), .data_valid(dv[0]), .row_end(re[0]), .frame_end(fe[0]), .busy(busy[0]),
        .underrun(und[0]), .clear_underrun(clr[0])
    );
    pixel_stream_tx #(.DATA_W(10), .LINE_W(4), .ROWS(2), .HBLANK(2), .VBLANK(3), .FIFO_DEPTH(2)) u_b (
        .clk(clk), .aclr(aclr), .in_data(din[1]), .in_valid(vld[1]), .in_ready(rdy[1]), .start(go_s[1]),
`ifdef PIX_TX_TESTPAT_EN
        .testpat(tp[1]),
`endif
        .data(dat[1]), .data_valid(dv[1]), .row_end(re[1]), .frame_end(fe[1]), .busy(busy[1]),
        .underrun(und[1]), .clear_underrun(clr[1])
    );
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask
    task automatic clr_mon();
        for (int k = 0; k < 2; k++) begin
            run[k] = 0; gap[k] = 0; mingap[k] = 999; badrun[k] = 0; stray[k] = 0; ended[k] = 0;
        end
        cap0.delete();
        cap1.delete();
    endtask
    task automatic src(input int k, input int first, input int last);
        nxt[k] = first;
        lim[k] = last;
        vld[k] = first <= last;
        din[k] = 10'(first);
    endtask
    // One clock: commit handshakes seen before the edge, then sample outputs 1 time unit after it.
    task automatic cyc();
        bit acc [2];
        for (int k = 0; k < 2; k++) acc[k] = vld[k] && rdy[k];
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (acc[k]) nxt[k]++;
            vld[k] = nxt[k] <= lim[k];
            din[k] = 10'(nxt[k]);
            if ((re[k] || fe[k]) && !dv[k]) stray[k]++;
            if (dv[k]) begin
                if (run[k] == 0 && ended[k]) mingap[k] = gap[k] < mingap[k] ? gap[k] : mingap[k];
                run[k]++;
                if (k == 0) cap0.push_back({dat[k], re[k], fe[k]});
                else cap1.push_back({dat[k], re[k], fe[k]});
            end else begin
                if (run[k] != 0) begin
                    if (run[k] != 4) badrun[k]++;
                    ended[k] = 1;
                    gap[k] = 0;
                end
                run[k] = 0;
                gap[k]++;
            end
        end
    endtask
    task automatic rst();
        aclr = 1'b0;
        go_s = '0;
        clr  = '0;
`ifdef PIX_TX_TESTPAT_EN
        tp = '0;
`endif
        src(0, 1, 0);
        src(1, 1, 0);
        @(posedge clk);
        #1;
        aclr = 1'b1;
        clr_mon();
    endtask
    task automatic go(input int k);
        go_s[k] = 1'b1;
        cyc();
        go_s[k] = 1'b0;
    endtask
    task automatic wait_frame(input int k, input string nm);
        bit seen, done;
        seen = 0;
        done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            cyc();
            if (busy[k]) seen = 1;
            else if (seen) done = 1;
        end
        chk({nm, ".frame_done"}, 32'(done), 1);
    endtask
    task automatic check_cap(input int k, input string nm, input int base, input int n, input int add);
        rec_t g, e;
        chk({nm, ".count"}, k == 0 ? cap0.size() : cap1.size(), n);
        for (int i = 0; i < n; i++) begin
            g = '1;
            if (k == 0 && i < cap0.size()) g = cap0[i];
            if (k == 1 && i < cap1.size()) g = cap1[i];
            e = tbl[base + i];
            e.d = e.d + 10'(add);
            chk($sformatf("%s[%0d].data", nm, i), 32'(g.d), 32'(e.d));
            chk($sformatf("%s[%0d].row_end", nm, i), 32'(g.re), 32'(e.re));
            chk($sformatf("%s[%0d].frame_end", nm, i), 32'(g.fe), 32'(e.fe));
        end
    endtask
    initial begin
        int bd [8] = '{1, 2, 3, 4, 5, 6, 0, 0};
        int td [8] = '{0, 1, 2, 3, 1, 2, 3, 4};
        bit ok;
        for (int i = 0; i < 8; i++) begin
            tbl[i]      = '{10'(i + 1), i % 4 == 3, i == 7};
            tbl[8 + i]  = '{10'(bd[i]), i % 4 == 3, i == 7};
            tbl[16 + i] = '{10'(td[i]), i % 4 == 3, i == 7};
        end
        go_s = '0; clr = '0; vld = '0; din[0] = '0; din[1] = '0;
`ifdef PIX_TX_TESTPAT_EN
        tp = '0;
`endif
        #12;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst%0d.in_ready", k), 32'(rdy[k]), 1);
            chk($sformatf("rst%0d.flags", k), {dv[k], re[k], fe[k], busy[k], und[k]}, 0);
            chk($sformatf("rst%0d.data", k), 32'(dat[k]), 0);
        end
        aclr = 1'b1;
        clr_mon();
        cyc();
        chk("rst.idle_busy", 32'(busy), 0);
        // Basic frame: source streams 1..8 while the frame runs.
        rst();
        src(0, 1, 8);
        go(0);
        wait_frame(0, "t1");
        check_cap(0, "t1", 0, 8, 0);
        chk("t1.row_gap", mingap[0], 3);
        chk("t1.vblank_idle", gap[0], 3);
        chk("t1.run_len_bad", badrun[0], 0);
        chk("t1.stray_pulse", stray[0], 0);
        chk("t1.underrun", 32'(und[0]), 0);
        // Primed start latency, then row 1 starved until more pixels arrive.
        rst();
        src(0, 1, 4);
        repeat (8) cyc();
        chk("t2.full_ready", 32'(rdy[0]), 0);
        go(0);
        chk("t2.t1_busy", 32'(busy[0]), 1);
        chk("t2.t1_valid", 32'(dv[0]), 0);
        cyc();
        chk("t2.t2_valid", 32'(dv[0]), 0);
        cyc();
        chk("t2.t3_valid", 32'(dv[0]), 1);
        chk("t2.t3_data", 32'(dat[0]), 1);
        repeat (30) cyc();
        chk("t2.stall_count", cap0.size(), 4);
        chk("t2.stall_busy", 32'(busy[0]), 1);
        chk("t2.stall_valid", 32'(dv[0]), 0);
        src(0, 5, 8);
        wait_frame(0, "t2");
        check_cap(0, "t2", 0, 8, 0);
        chk("t2.underrun", 32'(und[0]), 0);
        // Full FIFO back-pressures; the held pixel is taken once space frees.
        rst();
        src(0, 1, 5);
        repeat (8) cyc();
        chk("t4.in_ready", 32'(rdy[0]), 0);
        chk("t4.accepted_next", nxt[0], 5);
        chk("t4.still_offered", 32'(vld[0]), 1);
        chk("t4.offered_data", 32'(din[0]), 5);
        go(0);
        repeat (12) cyc();
        check_cap(0, "t4", 0, 4, 0);
        chk("t4.late_accept", nxt[0], 6);
        // Depth-2 instance: row 1 underruns and pads with zero.
        rst();
        src(1, 1, 6);
        go(1);
        wait_frame(1, "t3");
        check_cap(1, "t3", 8, 8, 0);
        chk("t3.run_len_bad", badrun[1], 0);
        chk("t3.underrun_set", 32'(und[1]), 1);
        repeat (3) cyc();
        chk("t3.underrun_sticky", 32'(und[1]), 1);
        clr[1] = 1'b1;
        cyc();
        clr[1] = 1'b0;
        chk("t3.underrun_clear", 32'(und[1]), 0);
        // Async clear on row 1 pixel 2, then a fresh frame.
        rst();
        src(0, 1, 8);
        go(0);
        ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            cyc();
            ok = cap0.size() == 6;
        end
        chk("t5.reach_row1", 32'(ok), 1);
        #1 aclr = 1'b0;
        #1;
        chk("t5.valid", 32'(dv[0]), 0);
        chk("t5.busy", 32'(busy[0]), 0);
        chk("t5.in_ready", 32'(rdy[0]), 1);
        chk("t5.data", 32'(dat[0]), 0);
        chk("t5.row_end", 32'(re[0]), 0);
        @(negedge clk);
        aclr = 1'b1;
        @(posedge clk);
        #1;
        clr_mon();
        src(0, 9, 16);
        go(0);
        wait_frame(0, "t5");
        check_cap(0, "t5", 0, 8, 8);
        chk("t5.stray_pulse", stray[0], 0);
`ifdef PIX_TX_TESTPAT_EN
        rst();
        tp[0] = 1'b1;
        go(0);
        tp[0] = 1'b0;
        wait_frame(0, "t6");
        check_cap(0, "t6", 16, 8, 0);
        chk("t6.underrun", 32'(und[0]), 0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end
endmodule
